agc_loop_ctrl: RTL and testbench
================================

Name: agc_loop_ctrl

Overview:
Closed-loop AGC controller that consumes the per-sample gt/lt threshold flags from a bank of AGC DSP lanes. Over a programmable integration period it counts threshold crossings, then computes new scale and offset values. It loads them into the DSP first-stage registers (ce_scale/ce_offset) and pulses a single global apply so every lane switches together. Sits beside the AGC DSP bank in the same clock domain.

Parameters:
NSAMP, 8, samples (lanes) presented per clock
PERIOD_LOG2, 17, integration period = 2^PERIOD_LOG2 clocks
OFFSET_BITS, 12, width of signed offset word
SCALE_INIT, 4096, scale after reset (unity gain in Q12)
OFFSET_INIT, 0, offset after reset
STEP_SHIFT, 6, scale step = scale >> STEP_SHIFT (minimum step 1)
CNT_BITS, PERIOD_LOG2+4, accumulator width (holds NSAMP*2^PERIOD_LOG2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  loop enable; sampled only in IDLE
gt_i  in  NSAMP  per-lane "sample above +threshold" flags
lt_i  in  NSAMP  per-lane "sample below -threshold" flags
target_hi_i  in  CNT_BITS  outlier count above which gain is reduced
target_lo_i  in  CNT_BITS  outlier count below which gain is increased
offset_db_i  in  CNT_BITS  gt/lt imbalance deadband
scale_o  out  17  scale word to the DSP B input
offset_o  out  OFFSET_BITS  signed offset word to the DSP A input
ce_scale_o  out  1  load strobe for the scale first stage
ce_offset_o  out  1  load strobe for the offset first stage
apply_o  out  1  global transfer strobe to the second stage
done_o  out  1  one-cycle pulse, asserted with apply_o

Behaviour:
- Reset: scale_o=SCALE_INIT, offset_o=OFFSET_INIT, all strobes 0, counters 0, state IDLE.
- States: IDLE -> ACCUM -> COMPUTE -> LOAD -> APPLY -> (ACCUM if en_i else IDLE).
- IDLE: counters cleared. Go to ACCUM when en_i=1.
- ACCUM:
  - Each clock, gt_cnt += popcount(gt_i) and lt_cnt += popcount(lt_i), one pipeline register after popcount.
  - The period counter runs 2^PERIOD_LOG2 clocks, then the pipeline drains one clock before COMPUTE.
  - Accumulators saturate at all-ones and never wrap.
  - A lane asserting gt_i and lt_i together is counted in both.
- COMPUTE (1 clock): tot = gt_cnt + lt_cnt, computed at CNT_BITS+1 width.
  - tot > target_hi_i: scale_next = scale_o - step.
  - tot < target_lo_i: scale_next = scale_o + step.
  - Otherwise scale unchanged. Both compares are strict.
  - step = max(scale_o >> STEP_SHIFT, 1).
  - scale_next clamps to [1, 131071].
  - If target_lo_i > target_hi_i, the decrease branch takes priority.
  - gt_cnt > lt_cnt + offset_db_i: offset_next = offset_o - 1.
  - lt_cnt > gt_cnt + offset_db_i: offset_next = offset_o + 1.
  - offset_next clamps to signed min/max of OFFSET_BITS.
- LOAD (1 clock): scale_o/offset_o take the new values. ce_scale_o=1 only if scale changed; ce_offset_o=1 only if offset changed.
- APPLY (1 clock): apply_o=1 and done_o=1. apply_o pulses even when nothing changed. Counters clear.
- en_i deasserted mid-period: the period completes and the update is applied, then the block returns to IDLE.
- rst_i mid-operation: immediate return to reset values. Strobes are never left high.
- Latency: apply_o occurs 2^PERIOD_LOG2 + 4 clocks after entering ACCUM.

Optional Feature:
AGC_LOOP_STATS_EN
- Defined: adds outputs last_gt_o and last_lt_o (CNT_BITS each). Both latch the final counts in COMPUTE and reset to 0.
- Undefined: these ports and registers do not exist.
- Loop behaviour is identical either way.

Decomposition:
- Shared package agc_pkg: state enum typedef, SCALE_MAX=131071, SCALE_MIN=1, and a function returning signed offset min/max for a given width.
- Sub-module agc_popcount (NSAMP-bit registered popcount), instantiated twice, for gt and lt.

Test Plan:
1. Reset, then en_i=1 with PERIOD_LOG2=4 and no flags, target_lo=1 -> after 20 clocks: ce_scale_o pulse, scale_o=4160, apply_o and done_o one clock later.
2. gt_i=lt_i=8'hFF every clock, target_hi=10 -> scale_o=4096-64=4032, offset_o unchanged, ce_offset_o=0.
3. gt_i=8'h0F, lt_i=0, offset_db=5 -> offset_o=-1 (12'hFFF), ce_offset_o=1. Repeat until the clamp: offset_o holds at 12'h800.
4. scale_o=1 under persistent overload -> stays 1, ce_scale_o=0, apply_o still pulses.
5. Drop en_i mid-ACCUM -> one apply_o pulse, then IDLE with no further strobes.
6. rst_i asserted during LOAD -> next clock: scale_o=4096, offset_o=0, all strobes 0.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC loop controller.
//   agc_state_e  : controller state encoding (also exported on the debug port)
//   SCALE_MIN/MAX: legal range of the Q12 scale word (17 bits unsigned)
//   offset_limit : signed min or max representable in a given offset width
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_LOAD    = 3'd3,
    ST_APPLY   = 3'd4
  } agc_state_e;

  localparam int unsigned SCALE_BITS = 17;
  localparam int unsigned SCALE_MAX  = 131071;
  localparam int unsigned SCALE_MIN  = 1;

  // want_max=1 returns the largest positive value, otherwise the most negative.
  function automatic int offset_limit(input int width, input bit want_max);
    if (want_max) return (1 << (width - 1)) - 1;
    else          return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/agc_popcount.sv
// Registered population count of an N-bit flag vector.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears the count)
//   bits_i  : flag vector
//   count_o : number of ones in bits_i, one clock later
module agc_popcount #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + W'(bits_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_o <= '0;
    else       count_o <= sum;
  end

endmodule

// File: rtl/agc_loop_ctrl.sv
// Closed-loop AGC controller. Counts gt/lt threshold crossings from NSAMP
// lanes over 2^PERIOD_LOG2 clocks, derives a new scale and offset, loads them
// into the DSP first-stage registers and pulses one global apply.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   en_i                    : loop enable (checked in IDLE and at the end of APPLY)
//   gt_i, lt_i              : per-lane above/below threshold flags
//   target_hi_i/target_lo_i : outlier-count window for gain decrease/increase
//   offset_db_i             : gt/lt imbalance deadband
//   scale_o, offset_o       : current scale (Q12) and signed offset words
//   ce_scale_o, ce_offset_o : first-stage load strobes, only when the value changed
//   apply_o, done_o         : one-cycle global transfer / period-complete pulse
//   state_o                 : debug view of the controller state (agc_state_e)
//
// Optional build macro AGC_LOOP_STATS_EN adds last_gt_o/last_lt_o, the final
// gt/lt counts of the most recent period.
//
// Handshake: there is no backpressure. The strobes are single-cycle pulses;
// ce_* is high in the APPLY-state cycle and apply_o/done_o follow on the
// next clock, 2^PERIOD_LOG2+4 clocks after the edge that entered ACCUM.
module agc_loop_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned NSAMP       = 8,
  parameter int unsigned PERIOD_LOG2 = 17,
  parameter int unsigned OFFSET_BITS = 12,
  parameter int unsigned SCALE_INIT  = 4096,
  parameter int          OFFSET_INIT = 0,
  parameter int unsigned STEP_SHIFT  = 6,
  parameter int unsigned CNT_BITS    = PERIOD_LOG2 + 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [NSAMP-1:0]              gt_i,
  input  logic [NSAMP-1:0]              lt_i,
  input  logic [CNT_BITS-1:0]           target_hi_i,
  input  logic [CNT_BITS-1:0]           target_lo_i,
  input  logic [CNT_BITS-1:0]           offset_db_i,
  output logic [SCALE_BITS-1:0]         scale_o,
  output logic signed [OFFSET_BITS-1:0] offset_o,
  output logic                          ce_scale_o,
  output logic                          ce_offset_o,
  output logic                          apply_o,
  output logic                          done_o,
`ifdef AGC_LOOP_STATS_EN
  output logic [CNT_BITS-1:0]           last_gt_o,
  output logic [CNT_BITS-1:0]           last_lt_o,
`endif
  output logic [2:0]                    state_o
);

  localparam int unsigned PC_W = $clog2(NSAMP + 1);
  localparam int unsigned AW   = CNT_BITS + 1;

  localparam logic [SCALE_BITS-1:0]         SCALE_RST = SCALE_BITS'(SCALE_INIT);
  localparam logic signed [OFFSET_BITS-1:0] OFF_RST   = OFFSET_BITS'(OFFSET_INIT);
  localparam logic signed [OFFSET_BITS-1:0] OFF_MIN   = OFFSET_BITS'(offset_limit(OFFSET_BITS, 1'b0));
  localparam logic signed [OFFSET_BITS-1:0] OFF_MAX   = OFFSET_BITS'(offset_limit(OFFSET_BITS, 1'b1));
  localparam logic signed [OFFSET_BITS-1:0] OFF_ONE   = OFFSET_BITS'(1);

  agc_state_e state;

  logic [PERIOD_LOG2:0]          period_cnt;
  logic                          samp_v;     // popcount register holds an in-window sample
  logic [CNT_BITS-1:0]           gt_cnt, lt_cnt;
  logic [PC_W-1:0]               gt_pc, lt_pc;
  logic [SCALE_BITS-1:0]         scale_nx;
  logic signed [OFFSET_BITS-1:0] offset_nx;

  assign state_o = state;

  agc_popcount #(.N(NSAMP), .W(PC_W)) u_pc_gt (
    .clk_i(clk_i), .rst_i(rst_i), .bits_i(gt_i), .count_o(gt_pc)
  );

  agc_popcount #(.N(NSAMP), .W(PC_W)) u_pc_lt (
    .clk_i(clk_i), .rst_i(rst_i), .bits_i(lt_i), .count_o(lt_pc)
  );

  // Saturating accumulation: the extra top bit flags overflow.
  logic [AW-1:0] gt_sum, lt_sum;
  assign gt_sum = {1'b0, gt_cnt} + AW'(gt_pc);
  assign lt_sum = {1'b0, lt_cnt} + AW'(lt_pc);

  // Update rules, evaluated from the final counts while in COMPUTE.
  logic [AW-1:0]               tot, gt_ext, lt_ext, db_ext;
  logic [SCALE_BITS-1:0]       step, scale_calc;
  logic [SCALE_BITS:0]         scale_inc;
  logic signed [OFFSET_BITS-1:0] offset_calc;

  always_comb begin
    gt_ext = {1'b0, gt_cnt};
    lt_ext = {1'b0, lt_cnt};
    db_ext = {1'b0, offset_db_i};
    tot    = gt_ext + lt_ext;

    step = scale_o >> STEP_SHIFT;
    if (step == '0) step = SCALE_BITS'(1);
    scale_inc = {1'b0, scale_o} + {1'b0, step};

    // Decrease is tested first so an inverted target window reduces gain.
    scale_calc = scale_o;
    if (tot > {1'b0, target_hi_i}) begin
      if (scale_o <= step) scale_calc = SCALE_BITS'(SCALE_MIN);
      else                 scale_calc = scale_o - step;
    end else if (tot < {1'b0, target_lo_i}) begin
      if (scale_inc > (SCALE_BITS + 1)'(SCALE_MAX)) scale_calc = SCALE_BITS'(SCALE_MAX);
      else                                          scale_calc = scale_inc[SCALE_BITS-1:0];
    end

    // Too many positive outliers pulls the offset down, and vice versa.
    offset_calc = offset_o;
    if (gt_ext > lt_ext + db_ext) begin
      if (offset_o != OFF_MIN) offset_calc = offset_o - OFF_ONE;
    end else if (lt_ext > gt_ext + db_ext) begin
      if (offset_o != OFF_MAX) offset_calc = offset_o + OFF_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      period_cnt  <= '0;
      samp_v      <= 1'b0;
      gt_cnt      <= '0;
      lt_cnt      <= '0;
      scale_nx    <= SCALE_RST;
      offset_nx   <= OFF_RST;
      scale_o     <= SCALE_RST;
      offset_o    <= OFF_RST;
      ce_scale_o  <= 1'b0;
      ce_offset_o <= 1'b0;
      apply_o     <= 1'b0;
      done_o      <= 1'b0;
`ifdef AGC_LOOP_STATS_EN
      last_gt_o   <= '0;
      last_lt_o   <= '0;
`endif
    end else begin
      ce_scale_o  <= 1'b0;
      ce_offset_o <= 1'b0;
      apply_o     <= 1'b0;
      done_o      <= 1'b0;

      // Inputs are sampled on ACCUM cycles 0..2^P-1; the last cycle
      // (period_cnt[P] set) only drains the popcount register.
      samp_v <= (state == ST_ACCUM) && !period_cnt[PERIOD_LOG2];
      if (samp_v) begin
        gt_cnt <= gt_sum[CNT_BITS] ? '1 : gt_sum[CNT_BITS-1:0];
        lt_cnt <= lt_sum[CNT_BITS] ? '1 : lt_sum[CNT_BITS-1:0];
      end

      case (state)
        ST_IDLE: begin
          period_cnt <= '0;
          gt_cnt     <= '0;
          lt_cnt     <= '0;
          if (en_i) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (period_cnt[PERIOD_LOG2]) state <= ST_COMPUTE;
          else                         period_cnt <= period_cnt + 1'b1;
        end
        ST_COMPUTE: begin
          scale_nx  <= scale_calc;
          offset_nx <= offset_calc;
`ifdef AGC_LOOP_STATS_EN
          last_gt_o <= gt_cnt;
          last_lt_o <= lt_cnt;
`endif
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          scale_o     <= scale_nx;
          offset_o    <= offset_nx;
          ce_scale_o  <= (scale_nx != scale_o);
          ce_offset_o <= (offset_nx != offset_o);
          state       <= ST_APPLY;
        end
        ST_APPLY: begin
          apply_o    <= 1'b1;
          done_o     <= 1'b1;
          period_cnt <= '0;
          gt_cnt     <= '0;
          lt_cnt     <= '0;
          state      <= en_i ? ST_ACCUM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Testbench for agc_loop_ctrl with a short integration period (2^4 clocks).
module tb_agc_loop_ctrl;
  import agc_pkg::*;

  localparam int NSAMP = 8;
  localparam int PL2   = 4;
  localparam int OB    = 12;
  localparam int CW    = PL2 + 4;
  localparam int PER   = 1 << PL2;
  localparam int CMAX  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, en;
  logic [NSAMP-1:0]     gt, lt;
  logic [CW-1:0]        thi, tlo, db;
  logic [16:0]          scale;
  logic signed [OB-1:0] offset;
  logic                 ce_s, ce_o, apply, done;
  logic [2:0]           state;
`ifdef AGC_LOOP_STATS_EN
  logic [CW-1:0]        last_gt, last_lt;
`endif

  agc_loop_ctrl #(
    .NSAMP(NSAMP), .PERIOD_LOG2(PL2), .OFFSET_BITS(OB),
    .SCALE_INIT(4096), .OFFSET_INIT(0), .STEP_SHIFT(6), .CNT_BITS(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .gt_i(gt), .lt_i(lt),
    .target_hi_i(thi), .target_lo_i(tlo), .offset_db_i(db),
    .scale_o(scale), .offset_o(offset),
    .ce_scale_o(ce_s), .ce_offset_o(ce_o), .apply_o(apply), .done_o(done),
`ifdef AGC_LOOP_STATS_EN
    .last_gt_o(last_gt), .last_lt_o(last_lt),
`endif
    .state_o(state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected {scale, offset} after each completed period.
  logic [16+OB:0] exp_q[$];
  int m_scale  = 4096;
  int m_offset = 0;
  int m_ce_s, m_ce_o;

  // Reference update rules applied to one period's totals.
  task automatic model_period(input int g, input int l, input int hi, input int lo, input int dbv);
    int s0, o0, step;
    s0 = m_scale;
    o0 = m_offset;
    if (g > CMAX) g = CMAX;
    if (l > CMAX) l = CMAX;
    step = m_scale / 64;
    if (step < 1) step = 1;
    if (g + l > hi)      m_scale = (m_scale - step < 1) ? 1 : m_scale - step;
    else if (g + l < lo) m_scale = (m_scale + step > 131071) ? 131071 : m_scale + step;
    if (g > l + dbv)      m_offset = (m_offset - 1 < -2048) ? -2048 : m_offset - 1;
    else if (l > g + dbv) m_offset = (m_offset + 1 > 2047) ? 2047 : m_offset + 1;
    m_ce_s = (m_scale != s0) ? 1 : 0;
    m_ce_o = (m_offset != o0) ? 1 : 0;
    exp_q.push_back({17'(m_scale), OB'(m_offset)});
  endtask

  // ---------------- driver ----------------
  // Called #1 after the edge that entered ACCUM. Drives one full period and
  // checks the load and apply cycles. rnd selects random flags (density
  // chosen per period) instead of gfix/lfix. en is set to en_after during
  // LOAD so the APPLY state sees it. drop_at>=0 clears en mid-period.
  // rst_load asserts reset while the DUT sits in LOAD and returns in IDLE.
  task automatic run_period(input bit rnd, input logic [NSAMP-1:0] gfix, input logic [NSAMP-1:0] lfix,
                            input bit en_after, input int drop_at, input bit rst_load);
    int g, l, dens;
    logic [16+OB:0] e;
    g = 0;
    l = 0;
    dens = $urandom_range(0, 2);
    for (int k = 0; k < PER; k++) begin
      if (rnd) begin
        case (dens)
          0:       begin gt = NSAMP'($urandom & $urandom & $urandom); lt = NSAMP'($urandom & $urandom); end
          1:       begin gt = NSAMP'($urandom); lt = NSAMP'($urandom & $urandom & $urandom); end
          default: begin gt = NSAMP'($urandom | $urandom); lt = NSAMP'($urandom); end
        endcase
        en = 1'($urandom);
      end else begin
        gt = gfix;
        lt = lfix;
      end
      if (k == drop_at) en = 1'b0;
      g += $countones(gt);
      l += $countones(lt);
      @(posedge clk); #1;
      check("accum_strobes", {ce_s, ce_o, apply, done}, 0);
    end
    // Flags from here on fall outside the window and must not be counted.
    gt = NSAMP'($urandom);
    lt = NSAMP'($urandom);
    @(posedge clk); #1;          // COMPUTE
    gt = NSAMP'($urandom);
    @(posedge clk); #1;          // LOAD
    check("load_state", state, ST_LOAD);
    if (rst_load) begin
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_scale  = 4096;
      m_offset = 0;
      check("rst_scale", scale, 4096);
      check("rst_offset", offset, 0);
      check("rst_strobes", {ce_s, ce_o, apply, done}, 0);
      check("rst_state", state, ST_IDLE);
      @(posedge clk); #1;
      check("rst_strobes2", {ce_s, ce_o, apply, done}, 0);
      return;
    end
    en = en_after;
    @(posedge clk); #1;          // APPLY: new values and load strobes visible
    model_period(g, l, int'(thi), int'(tlo), int'(db));
    e = exp_q.pop_front();
    check("scale", scale, e[16+OB:OB]);
    check("offset", $signed(offset), $signed(e[OB-1:0]));
    check("ce_scale", ce_s, m_ce_s);
    check("ce_offset", ce_o, m_ce_o);
    check("apply_early", apply, 0);
`ifdef AGC_LOOP_STATS_EN
    check("last_gt", last_gt, (g > CMAX) ? CMAX : g);
    check("last_lt", last_lt, (l > CMAX) ? CMAX : l);
`endif
    @(posedge clk); #1;          // apply pulse, DUT now in ACCUM or IDLE
    check("apply", apply, 1);
    check("done", done, 1);
    check("ce_clear", {ce_s, ce_o}, 0);
    check("next_state", state, en_after ? ST_ACCUM : ST_IDLE);
  endtask

  task automatic start_loop();
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_strobes", {ce_s, ce_o, apply, done}, 0);
      check("idle_state", state, ST_IDLE);
      check("idle_scale", scale, m_scale);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; en = 1'b0; gt = '0; lt = '0;
    thi = 8'd255; tlo = 8'd1; db = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_scale", scale, 4096);
    check("reset_offset", offset, 0);
    check("reset_strobes", {ce_s, ce_o, apply, done}, 0);
    check("reset_state", state, ST_IDLE);
    idle_cycles(3);

    // No flags below target_lo: gain up by 64.
    start_loop();
    run_period(1'b0, '0, '0, 1'b1, -1, 1'b0);
    check("t1_scale", scale, 4160);

    // Reset while LOAD is pending.
    thi = 8'd10; tlo = 8'd0;
    run_period(1'b0, '1, '1, 1'b0, -1, 1'b1);

    // Full overload, balanced gt/lt: gain down, offset untouched.
    start_loop();
    run_period(1'b0, '1, '1, 1'b0, -1, 1'b0);
    check("t2_scale", scale, 4032);
    check("t2_offset", offset, 0);

    // Random flags and thresholds (including inverted windows).
    start_loop();
    for (int p = 0; p < 40; p++) begin
      thi = CW'($urandom_range(0, 255));
      tlo = CW'($urandom_range(0, 255));
      db  = CW'($urandom_range(0, 40));
      run_period(1'b1, '0, '0, (p != 39), -1, 1'b0);
    end

    // Clean start, then drive offset to its negative clamp and scale to 1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_scale = 4096;
    m_offset = 0;
    thi = 8'd10; tlo = 8'd0; db = 8'd5;
    start_loop();
    run_period(1'b0, 8'h0F, 8'h00, 1'b1, -1, 1'b0);
    check("t3_offset_first", offset, -1);
    for (int p = 0; p < 2052; p++) begin
      run_period(1'b0, 8'h0F, 8'h00, (p != 2051), -1, 1'b0);
    end
    check("t3_offset_clamp", offset, -2048);
    check("t4_scale_floor", scale, 1);
    idle_cycles(2);

    // Enable dropped mid-period: one apply, then quiet IDLE.
    thi = 8'd255; tlo = 8'd0; db = 8'd0;
    start_loop();
    run_period(1'b0, 8'h00, 8'h03, 1'b0, 5, 1'b0);
    idle_cycles(10);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
